// File: rtl/reflet_mem_sequencer_if.sv
// Bundle of the CPU request/response and narrow memory-beat signals around
// the Reflet memory sequencer.
//
// Handshakes, all sampled on the rising clock edge:
//   request : accepted on an edge with req_valid && req_ready; the CPU holds
//             req_* stable while req_valid is high and req_ready is low.
//   beat    : completes on an edge with mem_req && mem_ready; the sequencer
//             holds mem_* stable while mem_ready is low. mem_ready without
//             mem_req means nothing.
//   response: rsp_valid is a single-cycle pulse with no backpressure.
interface reflet_mem_sequencer_if #(
  parameter int wordsize  = 16,
  parameter int bus_width = 8
);
  logic                   req_valid;
  logic                   req_ready;
  logic                   req_write;
  logic [wordsize-1:0]    req_addr;
  logic [1:0]             req_size;
  logic [wordsize-1:0]    req_wdata;
  logic                   rsp_valid;
  logic [wordsize-1:0]    rsp_rdata;
  logic                   rsp_error;
  logic                   mem_req;
  logic                   mem_write_en;
  logic [wordsize-1:0]    mem_addr;
  logic [bus_width-1:0]   mem_wdata;
  logic [bus_width/8-1:0] mem_byte_en;
  logic [bus_width-1:0]   mem_rdata;
  logic                   mem_ready;

  // Environment side: the CPU core plus the memory it talks to.
  modport master (
    output req_valid, req_write, req_addr, req_size, req_wdata,
    output mem_rdata, mem_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_error,
    input  mem_req, mem_write_en, mem_addr, mem_wdata, mem_byte_en
  );

  // Sequencer side.
  modport slave (
    input  req_valid, req_write, req_addr, req_size, req_wdata,
    input  mem_rdata, mem_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_error,
    output mem_req, mem_write_en, mem_addr, mem_wdata, mem_byte_en
  );
endinterface

// File: rtl/reflet_mem_sequencer.sv
// Splits one CPU load/store of 1..wordsize/8 bytes into bus_width-wide memory
// beats and assembles load data little-endian into a single response.
module reflet_mem_sequencer #(
  parameter int wordsize  = 16,
  parameter int bus_width = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  reflet_mem_sequencer_if.slave bus,
  output logic [1:0]           dbg_state
);
  localparam int BB     = bus_width / 8;
  localparam int WB     = wordsize / 8;
  localparam int LOG_BB = $clog2(BB);
  localparam int KW     = 4;

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] ACCESS = 2'd1;
  localparam logic [1:0] RESP   = 2'd2;

  logic [1:0]          state_q, state_d;
  logic                write_q, write_d;
  logic                err_q, err_d;
  logic [wordsize-1:0] addr_q, addr_d;
  logic [wordsize-1:0] wdata_q, wdata_d;
  logic [wordsize-1:0] asm_q, asm_d;
  logic [BB-1:0]       be_q, be_d;
  logic [KW-1:0]       last_q, last_d;
  logic [KW-1:0]       k_q, k_d;

  logic [3:0]           acc_nbytes;
  logic                 acc_err;
  logic [KW-1:0]        acc_last;
  logic [BB-1:0]        acc_be;
  logic [bus_width-1:0] lane_mask;

  // Decode the incoming request: byte count, error, index of the last beat, lanes.
  always_comb begin
    acc_nbytes = 4'd1 << bus.req_size;
    acc_err    = int'(acc_nbytes) > WB;
    acc_last   = '0;
    if (int'(bus.req_size) > LOG_BB)
      acc_last = KW'((1 << (int'(bus.req_size) - LOG_BB)) - 1);
    acc_be = '1;
    if (int'(acc_nbytes) < BB)
      acc_be = BB'((1 << int'(acc_nbytes)) - 1);
  end

  // Expand the byte-lane enables into a bit mask for load data.
  always_comb begin
    lane_mask = '0;
    for (int i = 0; i < BB; i++)
      lane_mask[i*8 +: 8] = {8{be_q[i]}};
  end

  // Next-state logic: accept, step through beats, pulse the response.
  // The address register advances by one bus word per beat and the write data
  // shifts down, so the current beat always sits at addr_q / wdata_q[low].
  always_comb begin
    state_d = state_q;
    write_d = write_q;
    err_d   = err_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    asm_d   = asm_q;
    be_d    = be_q;
    last_d  = last_q;
    k_d     = k_q;
    case (state_q)
      IDLE: begin
        if (bus.req_valid) begin
          write_d = bus.req_write;
          addr_d  = bus.req_addr;
          wdata_d = bus.req_wdata;
          be_d    = acc_be;
          last_d  = acc_last;
          err_d   = acc_err;
          k_d     = '0;
          asm_d   = '0;
          state_d = acc_err ? RESP : ACCESS;
        end
      end
      ACCESS: begin
        if (bus.mem_ready) begin
          if (!write_q)
            asm_d[int'(k_q)*bus_width +: bus_width] = bus.mem_rdata & lane_mask;
          addr_d  = addr_q + wordsize'(BB);
          wdata_d = wdata_q >> bus_width;
          k_d     = k_q + KW'(1);
          if (k_q == last_q)
            state_d = RESP;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State registers with synchronous reset; a partial access is dropped.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      write_q <= 1'b0;
      err_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      asm_q   <= '0;
      be_q    <= '0;
      last_q  <= '0;
      k_q     <= '0;
    end else begin
      state_q <= state_d;
      write_q <= write_d;
      err_q   <= err_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      asm_q   <= asm_d;
      be_q    <= be_d;
      last_q  <= last_d;
      k_q     <= k_d;
    end
  end

  // Outputs come only from registered state, never straight from req_*.
  always_comb begin
    bus.req_ready    = (state_q == IDLE);
    bus.mem_req      = (state_q == ACCESS);
    bus.mem_write_en = (state_q == ACCESS) && write_q;
    bus.mem_addr     = addr_q;
    bus.mem_wdata    = wdata_q[bus_width-1:0];
    bus.mem_byte_en  = (state_q == ACCESS) ? be_q : '0;
    bus.rsp_valid    = (state_q == RESP);
    bus.rsp_error    = (state_q == RESP) && err_q;
    bus.rsp_rdata    = ((state_q == RESP) && !write_q) ? asm_q : '0;
    dbg_state        = state_q;
  end
endmodule

// File: doc/reflet_mem_sequencer.md
Name: reflet_mem_sequencer

Overview:
- Parametrised memory-access sequencer between the Reflet CPU core and a narrow RAM/bus port.
- Takes one load/store request of 1..wordsize/8 bytes from the CPU.
- Splits it into bus_width-wide beats with a ready handshake per beat.
- Assembles read data little-endian and returns one response.
- Replaces fixed-width address muxing with width-independent, multi-beat access. This allows a 32/64-bit core to run on an 8- or 16-bit memory.

Parameters:
- wordsize, 16: CPU data and address width in bits. Must be 8, 16, 32 or 64.
- bus_width, 8: memory data width in bits. Must be 8, 16, 32 or 64, must be ≤ wordsize, and must divide wordsize.

Ports:
- clk  in  1  clock; all logic on rising edge
- reset  in  1  synchronous, active-high reset
- req_valid  in  1  CPU request present
- req_ready  out  1  sequencer can accept a request
- req_write  in  1  1=store, 0=load
- req_addr  in  wordsize  byte address of the first byte
- req_size  in  2  log2 of the byte count: 0=1 byte, 1=2, 2=4, 3=8
- req_wdata  in  wordsize  store data; the low bytes are used
- rsp_valid  out  1  one-cycle response pulse
- rsp_rdata  out  wordsize  load data, zero-extended; 0 for stores
- rsp_error  out  1  request size exceeds wordsize/8
- mem_req  out  1  beat request to memory
- mem_write_en  out  1  beat is a write
- mem_addr  out  wordsize  byte address of the current beat
- mem_wdata  out  bus_width  write data of the current beat
- mem_byte_en  out  bus_width/8  active byte lanes; lane 0 is at mem_addr
- mem_rdata  in  bus_width  read data of the current beat
- mem_ready  in  1  beat completes on any cycle where mem_req && mem_ready

Behaviour:
- Reset values: state IDLE, req_ready=1, mem_req=0, mem_write_en=0, mem_byte_en=0, rsp_valid=0, rsp_error=0, rsp_rdata=0, beat counter 0.
- Derived quantities:
  - nbytes = 1<<req_size.
  - bb = bus_width/8.
  - beats = ceil(nbytes/bb), minimum 1.
- States:
  - IDLE
  - ACCESS
  - RESP
- req_ready = (state==IDLE). The request is accepted on an edge where req_valid && req_ready.
- Capture on accept: write flag, address, wdata, nbytes, beats. Clear the assembly register.
- On accept with nbytes > wordsize/8:
  - Go to RESP with error set.
  - Issue no memory beat.
- On any other accept: go to ACCESS with beat counter k=0.
- ACCESS outputs, all registered or derived from registered state (no combinational path from req_* to mem_*):
  - mem_req=1.
  - mem_addr = addr + k*bb.
  - mem_write_en = write flag.
  - mem_wdata = wdata[k*bus_width +: bus_width].
  - mem_byte_en = all ones, except when nbytes < bb: low nbytes bits set.
- Beat completion (mem_req && mem_ready):
  - On a load, store mem_rdata into assembly[k*bus_width +: bus_width]. When nbytes < bb, bytes above nbytes are masked to 0.
  - If k == beats-1, go to RESP. Otherwise k+1 and stay in ACCESS.
  - mem_req stays high between beats, with the address and data updated on the completing edge.
- mem_ready low: hold all mem_* outputs stable indefinitely.
- RESP: rsp_valid=1 for exactly one cycle.
  - rsp_rdata = assembly on a load, 0 on a store.
  - rsp_error = error flag.
  - mem_req=0.
  - Next state IDLE. req_ready rises the following cycle.
- There is no response backpressure. The CPU must sample rsp_* in the pulse cycle.
- Latency with mem_ready tied high, counted in cycles after the accept edge: mem_req is high for cycles 1..beats, and rsp_valid is high in cycle beats+1.
- Error latency: rsp_valid in cycle 1.
- Address arithmetic wraps modulo 2^wordsize; no fault is raised.
- A req_valid that arrives while busy is ignored until req_ready=1. The CPU holds it.
- Reset asserted in any state, including mid-beat: the next edge returns to reset values. A partial beat is abandoned with no response.
- mem_ready asserted while mem_req=0 is ignored.

Test Plan:
1. wordsize=16, bus_width=8, load size=1 at 0x00FF, mem_rdata=0x12 with ready tied high → 2 beats at 0x00FF then 0x0100, byte_en=1 each, rsp_rdata=0x1200|… (low byte from 0x00FF), rsp_valid in cycle 3, error=0.
2. wordsize=32, bus_width=8, store size=2 of 0xAABBCCDD at 0x1000 → 4 beats: addr 0x1000..0x1003, wdata 0xDD, 0xCC, 0xBB, 0xAA, write_en=1; rsp_rdata=0.
3. wordsize=32, bus_width=16, load size=0 at 0x20, mem_rdata=0xBEEF → 1 beat, byte_en=01, rsp_rdata=0x000000EF.
4. wordsize=16, size=2 request → no mem_req, rsp_valid in cycle 1, rsp_error=1, rsp_rdata=0, req_ready back next cycle.
5. mem_ready low for 3 cycles on beat 0 of a 2-beat load → mem_addr and mem_req stable throughout; rsp_valid delayed exactly 3 cycles versus test 1.
6. reset pulsed during beat 1 of a 4-beat store → the next cycle shows mem_req=0, req_ready=1, no rsp_valid; a new request then completes normally with k starting at 0.
